// File: rtl/meta_pkg.sv
// Shared constants and types for the cache metadata array and its flush sequencer.
package meta_pkg;

  localparam int IDX_W     = 7;
  localparam int NUM_SETS  = 1 << IDX_W;
  localparam int TAG_W_DEF = 8;

  // Flush sequencer states: IDLE -> SWEEP -> DONE -> IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/meta_idx_dec.sv
// 7-to-128 one-hot index decoder producing per-entry write wordlines.
module meta_idx_dec
  import meta_pkg::*;
(
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_SETS-1:0] onehot
);

  // Raise exactly one wordline when enabled, none otherwise.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/meta_sweep_fsm.sv
// Flush sequencer: walks every set index once, one per cycle, then pulses flush_done.
module meta_sweep_fsm
  import meta_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done,
  output logic             sweep_en,
  output logic [IDX_W-1:0] sweep_idx
);

  sweep_state_e     state_q;
  sweep_state_e     state_d;
  logic [IDX_W-1:0] ptr_q;

  // Next-state logic; flush_req is only honoured from IDLE, never queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (flush_req) state_d = S_SWEEP;
      S_SWEEP: if (ptr_q == IDX_W'(NUM_SETS - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, sweep pointer and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Pointer rests at 0 while idle; increments through the sweep and wraps back to 0.
      if (state_q == S_SWEEP) ptr_q <= ptr_q + 1'b1;
      else                    ptr_q <= '0;
      busy       <= (state_d != S_IDLE);
      flush_done <= (state_d == S_DONE);
    end
  end

  assign sweep_en  = (state_q == S_SWEEP);
  assign sweep_idx = ptr_q;

endmodule

// File: rtl/meta_array_ctrl.sv
// 128-entry cache metadata array (valid + tag per set) with registered lookup and flush sweep.
module meta_array_ctrl
  import meta_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_cmp_tag,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];

  logic                sweep_en;
  logic [IDX_W-1:0]    sweep_idx;
  logic                wr_go;
  logic                rd_go;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_en;
  logic [NUM_SETS-1:0] sel;
  logic                entry_valid;
  logic [TAG_W-1:0]    entry_tag;

  meta_sweep_fsm u_sweep (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (flush_req),
    .busy       (busy),
    .flush_done (flush_done),
    .sweep_en   (sweep_en),
    .sweep_idx  (sweep_idx)
  );

  // Host accesses are accepted only while the sequencer is idle.
  assign wr_go = wr_en & ~busy;
  assign rd_go = rd_en & ~busy;

  // The single decoder serves both the host write port and the sweep pointer.
  assign dec_idx = sweep_en ? sweep_idx : wr_idx;
  assign dec_en  = sweep_en | wr_go;

  meta_idx_dec u_dec (
    .en     (dec_en),
    .idx    (dec_idx),
    .onehot (sel)
  );

  // Entry storage: sweep clears the valid bit only, a host write replaces valid and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset on purpose - reset must leave every valid bit and tag at zero.
      valid_q <= '0;
      for (int i = 0; i < NUM_SETS; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SETS; i++) begin
        if (sel[i]) begin
          if (sweep_en) begin
            valid_q[i] <= 1'b0;
          end else begin
            valid_q[i] <= wr_valid;
            tag_q[i]   <= wr_tag;
          end
        end
      end
    end
  end

  // Read mux observes pre-edge contents, so a same-cycle write is seen only by later reads.
  assign entry_valid = valid_q[rd_idx];
  assign entry_tag   = tag_q[rd_idx];

  // Registered lookup response; valid/tag hold when no lookup is accepted, hit drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_tag   <= '0;
      rd_hit   <= 1'b0;
    end else begin
      rd_ack <= rd_go;
      rd_hit <= rd_go & entry_valid & (entry_tag == rd_cmp_tag);
      if (rd_go) begin
        rd_valid <= entry_valid;
        rd_tag   <= entry_tag;
      end
    end
  end

endmodule

// File: tb/tb_meta_array_ctrl.sv
// Self-checking bench for meta_array_ctrl: directed vectors, flush corner cases, random vs model.
module tb_meta_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_req;
  logic       busy;
  logic       flush_done;
  logic       rd_en;
  logic [6:0] rd_idx;
  logic [7:0] rd_cmp_tag;
  logic       rd_ack;
  logic       rd_valid;
  logic [7:0] rd_tag;
  logic       rd_hit;
  logic       wr_en;
  logic [6:0] wr_idx;
  logic [7:0] wr_tag;
  logic       wr_valid;

  int n_checks = 0;
  int n_fail   = 0;

  meta_array_ctrl #(.TAG_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (flush_req),
    .busy       (busy),
    .flush_done (flush_done),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_cmp_tag (rd_cmp_tag),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_hit     (rd_hit),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_tag     (wr_tag),
    .wr_valid   (wr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd_en;
    logic [6:0] rd_idx;
    logic [7:0] cmp;
    logic       wr_en;
    logic [6:0] wr_idx;
    logic [7:0] wr_tag;
    logic       wr_valid;
    logic       e_ack;
    logic       e_valid;
    logic [7:0] e_tag;
    logic       e_hit;
  } vec_t;

  vec_t vecs [10];

  // Reference model state
  logic       m_valid [128];
  logic [7:0] m_tag   [128];
  int         busy_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_req  = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = '0;
    rd_cmp_tag = '0;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_tag     = '0;
    wr_valid   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [6:0] idx, input logic [7:0] tag, input logic v);
    wr_en = 1'b1; wr_idx = idx; wr_tag = tag; wr_valid = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [6:0] idx, input logic [7:0] cmp,
                            input logic e_valid, input logic [7:0] e_tag, input logic e_hit);
    rd_en = 1'b1; rd_idx = idx; rd_cmp_tag = cmp;
    tick();
    rd_en = 1'b0;
    check({name, ".ack"},   32'(rd_ack),   32'(1));
    check({name, ".valid"}, 32'(rd_valid), 32'(e_valid));
    check({name, ".tag"},   32'(rd_tag),   32'(e_tag));
    check({name, ".hit"},   32'(rd_hit),   32'(e_hit));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       saw_done;
    logic       saw_busy;
    logic       e_ack, e_valid, e_hit;
    logic [7:0] e_tag;

    // ---------------- reset state ----------------
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst.busy",   32'(busy),       32'(0));
    check("rst.done",   32'(flush_done), 32'(0));
    check("rst.ack",    32'(rd_ack),     32'(0));
    check("rst.valid",  32'(rd_valid),   32'(0));
    check("rst.tag",    32'(rd_tag),     32'(0));
    check("rst.hit",    32'(rd_hit),     32'(0));
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven directed vectors ----------------
    vecs[0] = '{1'b1, 7'd5,   8'hA5, 1'b0, 7'd0,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 7'd0,   8'h00, 1'b1, 7'd127, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 7'd127, 8'h3C, 1'b0, 7'd0,   8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1};
    vecs[3] = '{1'b1, 7'd127, 8'h3D, 1'b0, 7'd0,   8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{1'b1, 7'd9,   8'h11, 1'b1, 7'd9,   8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 7'd9,   8'h11, 1'b0, 7'd0,   8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
    vecs[6] = '{1'b1, 7'd9,   8'h12, 1'b1, 7'd9,   8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[7] = '{1'b1, 7'd9,   8'h22, 1'b0, 7'd0,   8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0};
    vecs[8] = '{1'b0, 7'd0,   8'h00, 1'b0, 7'd0,   8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0};
    vecs[9] = '{1'b1, 7'd0,   8'h00, 1'b0, 7'd0,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};

    for (int i = 0; i < 10; i++) begin
      rd_en = vecs[i].rd_en; rd_idx = vecs[i].rd_idx; rd_cmp_tag = vecs[i].cmp;
      wr_en = vecs[i].wr_en; wr_idx = vecs[i].wr_idx; wr_tag = vecs[i].wr_tag;
      wr_valid = vecs[i].wr_valid;
      tick();
      check($sformatf("vec%0d.ack", i),   32'(rd_ack),   32'(vecs[i].e_ack));
      check($sformatf("vec%0d.valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.tag", i),   32'(rd_tag),   32'(vecs[i].e_tag));
      check($sformatf("vec%0d.hit", i),   32'(rd_hit),   32'(vecs[i].e_hit));
    end
    idle_inputs();
    tick();

    // ---------------- full flush: timing, dropped reads, tags intact ----------------
    do_write(7'd0,   8'h01, 1'b1);
    do_write(7'd64,  8'h40, 1'b1);
    do_write(7'd127, 8'h7F, 1'b1);
    flush_req = 1'b1;                       // cycle n
    tick();
    flush_req = 1'b0;
    rd_en = 1'b1; rd_idx = 7'd64; rd_cmp_tag = 8'h40;
    saw_busy = 1'b1;
    saw_done = 1'b0;
    for (int k = 1; k <= 129; k++) begin    // now in cycle n+k
      if (busy !== 1'b1) saw_busy = 1'b0;
      if (k < 129 && flush_done !== 1'b0) saw_done = 1'b1;
      if (k == 129) check("flush.done_at_n129", 32'(flush_done), 32'(1));
      if (k == 20)  check("flush.rd_ack_busy",  32'(rd_ack),     32'(0));
      if (k == 20)  check("flush.rd_hit_busy",  32'(rd_hit),     32'(0));
      tick();
    end
    rd_en = 1'b0;
    check("flush.busy_n1_to_n129", 32'(saw_busy),   32'(1));
    check("flush.no_early_done",   32'(saw_done),   32'(0));
    check("flush.busy_n130",       32'(busy),       32'(0));
    check("flush.done_n130",       32'(flush_done), 32'(0));
    check("flush.rd_ack_n130",     32'(rd_ack),     32'(0));
    read_check("flush.idx0",   7'd0,   8'h01, 1'b0, 8'h01, 1'b0);
    read_check("flush.idx64",  7'd64,  8'h40, 1'b0, 8'h40, 1'b0);
    read_check("flush.idx127", 7'd127, 8'h7F, 1'b0, 8'h7F, 1'b0);

    // ---------------- write + flush same cycle ----------------
    wr_en = 1'b1; wr_idx = 7'd50; wr_tag = 8'h5A; wr_valid = 1'b1;
    flush_req = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k < 129; k++) tick();
    check("wrflush.done", 32'(flush_done), 32'(1));
    tick();
    read_check("wrflush.idx50", 7'd50, 8'h5A, 1'b0, 8'h5A, 1'b0);

    // ---------------- flush_req and write mid-sweep are ignored ----------------
    do_write(7'd3, 8'h33, 1'b1);
    flush_req = 1'b1;
    tick();                                 // cycle n+1
    flush_req = 1'b0;
    for (int k = 1; k < 129; k++) begin
      if (k == 40) begin
        flush_req = 1'b1;
        wr_en = 1'b1; wr_idx = 7'd3; wr_tag = 8'h55; wr_valid = 1'b1;
      end else begin
        idle_inputs();
      end
      tick();
    end
    idle_inputs();
    check("mid.done_n129", 32'(flush_done), 32'(1));
    tick();
    check("mid.busy_n130", 32'(busy), 32'(0));
    read_check("mid.idx3", 7'd3, 8'h55, 1'b0, 8'h33, 1'b0);

    // ---------------- reset in the middle of a sweep ----------------
    do_write(7'd20, 8'h20, 1'b1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 1; k < 60; k++) tick();    // now in cycle n+60
    rst_n = 1'b0;
    #1;
    check("rstmid.busy", 32'(busy),       32'(0));
    check("rstmid.done", 32'(flush_done), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int k = 0; k < 140; k++) begin
      if (flush_done !== 1'b0) saw_done = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
      tick();
    end
    check("rstmid.no_done_after", 32'(saw_done), 32'(0));
    check("rstmid.no_busy_after", 32'(saw_busy), 32'(0));
    read_check("rstmid.idx20", 7'd20, 8'h20, 1'b0, 8'h00, 1'b0);
    do_write(7'd5, 8'hAA, 1'b1);
    read_check("rstmid.idx5", 7'd5, 8'hAA, 1'b1, 8'hAA, 1'b1);

    // ---------------- randomized run against reference model ----------------
    do_reset();
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 8'h00;
    end
    busy_left = 0;
    e_ack = 1'b0; e_valid = 1'b0; e_tag = 8'h00; e_hit = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rd_en      = ($urandom_range(0, 1) == 1);
      rd_idx     = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
      rd_cmp_tag = ($urandom_range(0, 1) == 1) ? m_tag[rd_idx] : 8'($urandom);
      wr_en      = ($urandom_range(0, 4) < 2);
      wr_idx     = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
      wr_tag     = 8'($urandom);
      wr_valid   = ($urandom_range(0, 3) != 0);
      flush_req  = ($urandom_range(0, 299) == 0);

      if (busy_left == 0) begin
        e_ack = rd_en;
        if (rd_en) begin
          e_valid = m_valid[rd_idx];
          e_tag   = m_tag[rd_idx];
          e_hit   = e_valid && (e_tag == rd_cmp_tag);
        end else begin
          e_hit = 1'b0;
        end
        if (wr_en) begin
          m_valid[wr_idx] = wr_valid;
          m_tag[wr_idx]   = wr_tag;
        end
        if (flush_req) begin
          for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
          busy_left = 129;
        end
      end else begin
        e_ack = 1'b0;
        e_hit = 1'b0;
        busy_left--;
      end

      tick();
      check("rnd.ack",   32'(rd_ack),     32'(e_ack));
      check("rnd.valid", 32'(rd_valid),   32'(e_valid));
      check("rnd.tag",   32'(rd_tag),     32'(e_tag));
      check("rnd.hit",   32'(rd_hit),     32'(e_hit));
      check("rnd.busy",  32'(busy),       32'(busy_left > 0));
      check("rnd.done",  32'(flush_done), 32'(busy_left == 1));
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
